// File: rtl/spi_cfg_rx.sv
// SPI slave receiving 16-bit configuration commands, oversampled in the pck0 domain.
// Drives conf_word/divisor with one-cycle write strobes and reads current settings back on miso.
module spi_cfg_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CONF_RESET  = 8'h00,
    parameter logic [7:0]  DIV_RESET   = 8'h5F
) (
    input  logic       pck0,
    input  logic       rst,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       conf_stb,
    output logic       div_stb,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_spck_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_spck_prev;
    logic                   r_ncs_prev;
    logic [FW-1:0]          r_flush_cnt;
    logic                   r_armed;
    logic                   r_in_frame;
    logic [4:0]             r_bit_cnt;
    logic [15:0]            r_shift;
    logic [15:0]            r_readback;
    logic                   r_miso;
    logic [7:0]             r_conf_word;
    logic [7:0]             r_divisor;
    logic                   r_conf_stb;
    logic                   r_div_stb;
    logic                   r_frame_err;

    logic w_spck_s;
    logic w_ncs_s;
    logic w_mosi_s;
    logic w_spck_rise;
    logic w_spck_fall;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_flushed;

    always_comb begin
        w_spck_s    = r_spck_sync[SYNC_STAGES-1];
        w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
        w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
        w_spck_rise = w_spck_s & ~r_spck_prev;
        w_spck_fall = ~w_spck_s & r_spck_prev;
        w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
        w_ncs_fall  = ~w_ncs_s & r_ncs_prev;
        w_flushed   = (r_flush_cnt == FW'(SYNC_STAGES));
    end

    // The synchronisers reset to idle values, so after reset a frame may only open once a
    // genuinely sampled high ncs has been seen; a still-low ncs never opens a frame.
    always_ff @(posedge pck0) begin
        if (rst) begin
            r_spck_sync <= '0;
            r_ncs_sync  <= '1;
            r_mosi_sync <= '0;
            r_spck_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
            r_in_frame  <= 1'b0;
            r_bit_cnt   <= 5'd0;
            r_shift     <= 16'h0000;
            r_readback  <= 16'h0000;
            r_miso      <= 1'b0;
            r_conf_word <= CONF_RESET;
            r_divisor   <= DIV_RESET;
            r_conf_stb  <= 1'b0;
            r_div_stb   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_spck_sync <= {r_spck_sync[SYNC_STAGES-2:0], spck};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_spck_prev <= w_spck_s;
            r_ncs_prev  <= w_ncs_s;
            r_conf_stb  <= 1'b0;
            r_div_stb   <= 1'b0;
            r_frame_err <= 1'b0;

            if (!w_flushed) begin
                r_flush_cnt <= r_flush_cnt + FW'(1);
            end
            if (w_flushed && w_ncs_s) begin
                r_armed <= 1'b1;
            end

            if (w_ncs_rise && r_in_frame) begin
                // A coincident spck rise is deliberately dropped: the frame closes as-is.
                r_in_frame <= 1'b0;
                r_miso     <= 1'b0;
                if (r_bit_cnt == 5'd16) begin
                    case (r_shift[15:12])
                        4'b0001: begin
                            r_conf_word <= r_shift[7:0];
                            r_conf_stb  <= 1'b1;
                        end
                        4'b0010: begin
                            r_divisor <= r_shift[7:0];
                            r_div_stb <= 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_ncs_fall && r_armed && !r_in_frame) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= 5'd0;
                r_readback <= {r_conf_word, r_divisor};
                r_miso     <= 1'b0;
            end else if (r_in_frame) begin
                if (w_spck_rise && !w_ncs_s) begin
                    r_shift <= {r_shift[14:0], w_mosi_s};
                    if (r_bit_cnt != 5'd31) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                if (w_spck_fall) begin
                    r_readback <= {r_readback[14:0], 1'b0};
                end
                r_miso <= r_readback[15];
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign miso      = r_miso;
    assign conf_word = r_conf_word;
    assign divisor   = r_divisor;
    assign conf_stb  = r_conf_stb;
    assign div_stb   = r_div_stb;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_cfg_rx.sv
// Directed bench for spi_cfg_rx: register writes, opcode filtering, frame-length errors,
// miso read-back, strobe latency and reset in the middle of a frame.
module tb_spi_cfg_rx;

    logic       pck0 = 1'b0;
    logic       rst;
    logic       spck;
    logic       ncs;
    logic       mosi;
    logic       miso;
    logic [7:0] conf_word;
    logic [7:0] divisor;
    logic       conf_stb;
    logic       div_stb;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int n_conf = 0;
    int n_div  = 0;
    int n_err  = 0;

    spi_cfg_rx #(
        .SYNC_STAGES(2),
        .CONF_RESET (8'h00),
        .DIV_RESET  (8'h5F)
    ) u_dut (
        .pck0     (pck0),
        .rst      (rst),
        .spck     (spck),
        .ncs      (ncs),
        .mosi     (mosi),
        .miso     (miso),
        .conf_word(conf_word),
        .divisor  (divisor),
        .conf_stb (conf_stb),
        .div_stb  (div_stb),
        .frame_err(frame_err)
    );

    always #5 pck0 = ~pck0;

    always @(negedge pck0) begin
        if (conf_stb)  n_conf++;
        if (div_stb)   n_div++;
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift one bit in mode 0: mosi changes with spck low, miso sampled just before the rise.
    task automatic spi_bit(input logic b, inout logic [15:0] rb);
        mosi = b;
        repeat (5) @(negedge pck0);
        rb   = {rb[14:0], miso};
        spck = 1'b1;
        repeat (5) @(negedge pck0);
        spck = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits,
                              output logic [15:0] rb, output int lat);
        rb  = 16'h0000;
        lat = 0;
        @(negedge pck0);
        ncs = 1'b0;
        repeat (8) @(negedge pck0);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(data[i], rb);
        end
        repeat (5) @(negedge pck0);
        ncs = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge pck0);
            if (lat == 0 && (conf_stb || div_stb || frame_err)) lat = k;
        end
    endtask

    task automatic frame_check(input string tag, input logic [31:0] data, input int nbits,
                               input logic [7:0] exp_conf, input logic [7:0] exp_div,
                               input int exp_dc, input int exp_dd, input int exp_de,
                               input int exp_lat, output logic [15:0] rb);
        int c0, d0, e0, lat;
        c0 = n_conf;
        d0 = n_div;
        e0 = n_err;
        send_frame(data, nbits, rb, lat);
        check({tag, " conf_word"}, 32'(conf_word), 32'(exp_conf));
        check({tag, " divisor"}, 32'(divisor), 32'(exp_div));
        check({tag, " conf_stb count"}, 32'(n_conf - c0), 32'(exp_dc));
        check({tag, " div_stb count"}, 32'(n_div - d0), 32'(exp_dd));
        check({tag, " frame_err count"}, 32'(n_err - e0), 32'(exp_de));
        check({tag, " pulse latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rb;
        logic [15:0] part;
        int c0, d0, e0;

        rst  = 1'b1;
        spck = 1'b0;
        ncs  = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge pck0);
        rst = 1'b0;
        repeat (6) @(negedge pck0);

        check("reset conf_word", 32'(conf_word), 32'h00);
        check("reset divisor", 32'(divisor), 32'h5F);
        check("reset miso", 32'(miso), 32'h0);
        check("reset conf_stb", 32'(conf_stb), 32'h0);
        check("reset div_stb", 32'(div_stb), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);

        frame_check("wr conf 1005", 32'h1005, 16, 8'h05, 8'h5F, 1, 0, 0, 3, rb);
        check("readback before first write", 32'(rb), 32'h005F);
        frame_check("wr div 2017", 32'h2017, 16, 8'h05, 8'h17, 0, 1, 0, 3, rb);
        frame_check("opcode 3 30AA", 32'h30AA, 16, 8'h05, 8'h17, 0, 0, 0, 0, rb);
        check("readback 0517", 32'(rb), 32'h0517);
        frame_check("short 15 bits", 32'h1033, 15, 8'h05, 8'h17, 0, 0, 1, 3, rb);
        frame_check("long 17 bits", 32'h1033, 17, 8'h05, 8'h17, 0, 0, 1, 3, rb);
        frame_check("empty frame", 32'h0, 0, 8'h05, 8'h17, 0, 0, 1, 3, rb);

        // Reset after 8 bits of 1042 with ncs held low, then release ncs.
        c0 = n_conf;
        d0 = n_div;
        e0 = n_err;
        part = 16'h0000;
        @(negedge pck0);
        ncs = 1'b0;
        repeat (8) @(negedge pck0);
        for (int i = 15; i >= 8; i--) begin
            spi_bit(part[0] ^ part[0] ^ (16'h1042 >> i) & 16'h1, part);
        end
        rst = 1'b1;
        repeat (2) @(negedge pck0);
        rst = 1'b0;
        repeat (10) @(negedge pck0);
        check("mid reset miso low", 32'(miso), 32'h0);
        ncs = 1'b1;
        repeat (15) @(negedge pck0);
        check("mid reset conf_word", 32'(conf_word), 32'h00);
        check("mid reset divisor", 32'(divisor), 32'h5F);
        check("mid reset conf/div strobes", 32'((n_conf - c0) + (n_div - d0)), 32'h0);
        check("mid reset frame_err", 32'(n_err - e0), 32'h0);

        frame_check("after reset 1033", 32'h1033, 16, 8'h33, 8'h5F, 1, 0, 0, 3, rb);
        check("readback after reset", 32'(rb), 32'h005F);
        frame_check("wr div 2280", 32'h2280, 16, 8'h33, 8'h80, 0, 1, 0, 3, rb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
